flit_sink_monitor: RTL and testbench
====================================

# flit_sink_monitor

Receive-side counterpart to the flit-pattern injectors used for adder/link energy characterization. It accepts a flit stream under a valid/ready handshake and delimits packets with `in_last`. For each packet it measures switching activity: bit toggles against the previously accepted flit, the number of one-bits, the flit count, and the idle gap before the packet. It presents one report per packet on a second valid/ready port. It sits at the far end of the characterized datapath and turns raw traffic into per-packet activity figures for the energy model.

## Interface
- `DATA_W`, 34: flit width (two 17-bit operand halves concatenated).
- `PAYLOAD`, 20: expected flits per packet; used only for the length check.
- `CNT_W`, 16: width of every report counter; all counters saturate.
- `clk` input, 1: single clock; all logic on rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `in_valid` input, 1: flit present.
- `in_data` input, DATA_W: flit payload.
- `in_last` input, 1: flit is the final flit of its packet.
- `in_ready` output, 1: sink can accept a flit.
- `rpt_valid` output, 1: report available.
- `rpt_ready` input, 1: consumer takes the report.
- `rpt_flits` output, CNT_W: flits in the packet.
- `rpt_toggles` output, CNT_W: sum of popcount(flit XOR previous flit).
- `rpt_ones` output, CNT_W: sum of popcount(flit).
- `rpt_gap` output, CNT_W: idle cycles before the packet's first flit.
- `rpt_len_err` output, 1: `rpt_flits` != PAYLOAD.

## Operation
- FSM has three states.
  - IDLE: `in_ready`=1. The gap counter increments every cycle without an accepted flit.
  - RECV: `in_ready`=1.
  - REPORT: `in_ready`=0 and `rpt_valid`=1.
- Accept = `in_valid & in_ready`.
- On every accept:
  - `prev` <= `in_data`.
  - Flit, toggle and ones accumulators add 1, popcount(`in_data ^ prev`) and popcount(`in_data`), each saturating at 2^CNT_W-1.
- `prev` is not cleared between packets, because the bus holds its value during gaps. It resets to 0.
- Transitions:
  - IDLE→RECV on an accept with `in_last`=0.
  - IDLE→REPORT on an accept with `in_last`=1 (single-flit packet).
  - RECV→REPORT on an accept with `in_last`=1.
  - REPORT→IDLE on `rpt_valid & rpt_ready`.
- Entering REPORT copies the final accumulator values, including the last flit, into the `rpt_*` registers. `rpt_len_err` is computed against PAYLOAD from the unsaturated comparison of the flit count.
- Leaving REPORT clears the accumulators and the gap counter.
- Gap counter:
  - Counts cycles spent in IDLE from the end of the previous report handshake (or from reset release) up to the cycle before the first accept.
  - A flit accepted on the first IDLE cycle gives gap 0.
  - Saturates.
- Cycles in RECV with `in_valid`=0 are not counted anywhere.
- `in_last` is ignored unless accompanied by an accept.
- `in_data` is ignored when there is no accept.

## Timing
- Reset values:
  - State IDLE; `in_ready`=1; `rpt_valid`=0.
  - All `rpt_*` outputs, accumulators, gap counter and `prev` are 0.
- Report latency: `rpt_valid` rises on the clock edge that accepts the last flit, and is visible the following cycle.
- While `rpt_valid`=1:
  - All `rpt_*` outputs are stable until the handshake.
  - `in_ready`=0; an upstream `in_valid` must be held.
- Minimum dead time between packets is one cycle (the REPORT cycle when `rpt_ready`=1). The next flit is accepted the cycle after the report handshake.
- Back-to-back packets are allowed. The first flit of packet k+1 is compared against the last flit of packet k.
- Reset asserted mid-packet or mid-report:
  - Accumulators and the partial packet are discarded and no report is emitted.
  - All outputs return to their reset values asynchronously.
- `in_ready` and `rpt_valid` are registered and do not depend combinationally on any input.

## Structure
- Shared package `flit_mon_pkg`:
  - FSM state enum (IDLE, RECV, REPORT).
  - A saturating-add function, parameterized by CNT_W.
- Sub-module `popcount` (parameter W, combinational, output width $clog2(W+1)). It is instantiated twice: once on `in_data ^ prev` and once on `in_data`.
- Everything else lives in `flit_sink_monitor`: FSM, accumulators, gap counter, report registers.

## Test plan
All scenarios use DATA_W=34 and PAYLOAD=20 unless stated.
- **Reset:** `rst_n` low.
  - Required: `in_ready`=1, `rpt_valid`=0, all `rpt_*`=0.
  - Release, idle for 3 cycles, then a 1-flit packet 0x000000000 with `in_last`.
  - Required: report flits=1, toggles=0, ones=0, gap=3, len_err=1.
- **Two-flit packet right after reset:** 0x3FFFF8000 then 0x03FFFFFFF with `in_last`.
  - Required: flits=2, toggles=38 (19+19), ones=49, gap=0, len_err=1.
  - `rpt_valid` high the cycle after the second flit is accepted.
- **Full packet:** 20 flits alternating 0x3FFFFFFFF / 0x000000000, starting from `prev`=0, with `in_last` on flit 20; then 7 idle cycles; then the next packet.
  - Required: flits=20, toggles=680, ones=340, len_err=0.
  - The next report has gap=7, counted after the report handshake.
- **Backpressure:** hold `rpt_ready`=0 for 5 cycles with `in_valid`=1 pending.
  - Required: `rpt_*` stable, `in_ready`=0, no flit accepted.
  - The pending flit is accepted the cycle after the handshake.
- **Saturation:** CNT_W=8, same alternating 20-flit packet.
  - Required: toggles=255, ones=255, flits=20, no wrap.
- **Reset mid-packet:** drop `rst_n` after 5 accepted flits, then send a 1-flit packet 0x000000001.
  - Required: no report for the aborted packet; new report toggles=1, ones=1, flits=1.

Source files
------------

// File: rtl/flit_mon_pkg.sv
// Shared types and helpers for the flit sink monitor: FSM state encoding and
// a width-generic saturating adder used by every report counter.
package flit_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int unsigned SAT_MAX_W = 32;

    // Adds a + b and clamps to 2^w-1; operands are zero-extended to SAT_MAX_W.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        if (sum > lim) begin
            return lim[SAT_MAX_W-1:0];
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/flit_sink_monitor_popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
    parameter int unsigned W = 34
) (
    input  logic [W-1:0]             vec_i,
    output logic [$clog2(W+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(W+1);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count_o = count_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/flit_sink_monitor.sv
// Per-packet switching-activity monitor: accumulates flit count, bit toggles,
// one-bits and the idle gap before each packet, and reports them per packet.
module flit_sink_monitor
    import flit_mon_pkg::*;
#(
    parameter int unsigned DATA_W  = 34,
    parameter int unsigned PAYLOAD = 20,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_flits,
    output logic [CNT_W-1:0]  rpt_toggles,
    output logic [CNT_W-1:0]  rpt_ones,
    output logic [CNT_W-1:0]  rpt_gap,
    output logic              rpt_len_err
);

    localparam int unsigned PC_W = $clog2(DATA_W+1);

    state_e              state_q;
    logic                in_ready_q;
    logic                rpt_valid_q;
    logic [DATA_W-1:0]   prev_q;
    logic [CNT_W-1:0]    flits_q;
    logic [CNT_W-1:0]    tog_q;
    logic [CNT_W-1:0]    ones_q;
    logic [CNT_W-1:0]    gap_q;
    logic                flit_ovf_q;
    logic [CNT_W-1:0]    rpt_flits_q;
    logic [CNT_W-1:0]    rpt_tog_q;
    logic [CNT_W-1:0]    rpt_ones_q;
    logic [CNT_W-1:0]    rpt_gap_q;
    logic                rpt_len_err_q;

    logic [PC_W-1:0]     tog_pc;
    logic [PC_W-1:0]     ones_pc;
    logic [CNT_W:0]      flits_wide;
    logic [CNT_W-1:0]    flits_d;
    logic [CNT_W-1:0]    tog_d;
    logic [CNT_W-1:0]    ones_d;
    logic [CNT_W-1:0]    gap_d;
    logic                flit_ovf_d;
    logic                len_err_d;
    logic                accept;

    popcount #(.W(DATA_W)) u_pc_tog (
        .vec_i   (in_data ^ prev_q),
        .count_o (tog_pc)
    );

    popcount #(.W(DATA_W)) u_pc_ones (
        .vec_i   (in_data),
        .count_o (ones_pc)
    );

    assign accept = in_valid & in_ready_q;

    // Length check uses one extra bit plus a sticky overflow flag so a
    // saturated flit counter can never alias onto PAYLOAD.
    always_comb begin
        flits_wide = {1'b0, flits_q} + (CNT_W+1)'(1);
        flits_d    = CNT_W'(sat_add(32'(flits_q), 32'd1, CNT_W));
        tog_d      = CNT_W'(sat_add(32'(tog_q), 32'(tog_pc), CNT_W));
        ones_d     = CNT_W'(sat_add(32'(ones_q), 32'(ones_pc), CNT_W));
        gap_d      = CNT_W'(sat_add(32'(gap_q), 32'd1, CNT_W));
        flit_ovf_d = flit_ovf_q | flits_wide[CNT_W];
        len_err_d  = flit_ovf_d | (flits_wide != (CNT_W+1)'(PAYLOAD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            rpt_valid_q   <= 1'b0;
            prev_q        <= '0;
            flits_q       <= '0;
            tog_q         <= '0;
            ones_q        <= '0;
            gap_q         <= '0;
            flit_ovf_q    <= 1'b0;
            rpt_flits_q   <= '0;
            rpt_tog_q     <= '0;
            rpt_ones_q    <= '0;
            rpt_gap_q     <= '0;
            rpt_len_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RECV: begin
                    if (accept) begin
                        prev_q     <= in_data;
                        flits_q    <= flits_d;
                        tog_q      <= tog_d;
                        ones_q     <= ones_d;
                        flit_ovf_q <= flit_ovf_d;
                        if (in_last) begin
                            state_q       <= ST_REPORT;
                            in_ready_q    <= 1'b0;
                            rpt_valid_q   <= 1'b1;
                            rpt_flits_q   <= flits_d;
                            rpt_tog_q     <= tog_d;
                            rpt_ones_q    <= ones_d;
                            rpt_gap_q     <= gap_q;
                            rpt_len_err_q <= len_err_d;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end else if (state_q == ST_IDLE) begin
                        gap_q <= gap_d;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        rpt_valid_q <= 1'b0;
                        flits_q     <= '0;
                        tog_q       <= '0;
                        ones_q      <= '0;
                        gap_q       <= '0;
                        flit_ovf_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    rpt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign rpt_valid   = rpt_valid_q;
    assign rpt_flits   = rpt_flits_q;
    assign rpt_toggles = rpt_tog_q;
    assign rpt_ones    = rpt_ones_q;
    assign rpt_gap     = rpt_gap_q;
    assign rpt_len_err = rpt_len_err_q;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Scoreboard bench for flit_sink_monitor: a 16-bit-counter instance checked
// against queued expectations, plus an 8-bit-counter instance for saturation.
module tb_flit_sink_monitor;

    localparam int unsigned DATA_W  = 34;
    localparam int unsigned PAYLOAD = 20;
    localparam int unsigned CNT_W   = 16;
    localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              rpt_ready = 1'b0;

    logic              in_ready, rpt_valid, rpt_len_err;
    logic [CNT_W-1:0]  rpt_flits, rpt_toggles, rpt_ones, rpt_gap;
    logic              in_ready8, rpt_valid8, rpt_len_err8;
    logic [7:0]        rpt_flits8, rpt_toggles8, rpt_ones8, rpt_gap8;

    typedef struct packed {
        logic [15:0] flits;
        logic [15:0] toggles;
        logic [15:0] ones;
        logic [15:0] gap;
        logic        len_err;
    } rpt_t;

    rpt_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [DATA_W-1:0] m_prev;
    int unsigned       m_flits, m_tog, m_ones;

    always #5 clk = ~clk;

    flit_sink_monitor #(.DATA_W(DATA_W), .PAYLOAD(PAYLOAD), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_flits(rpt_flits), .rpt_toggles(rpt_toggles),
        .rpt_ones(rpt_ones), .rpt_gap(rpt_gap), .rpt_len_err(rpt_len_err)
    );

    flit_sink_monitor #(.DATA_W(DATA_W), .PAYLOAD(PAYLOAD), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready8), .rpt_valid(rpt_valid8),
        .rpt_ready(rpt_ready), .rpt_flits(rpt_flits8), .rpt_toggles(rpt_toggles8),
        .rpt_ones(rpt_ones8), .rpt_gap(rpt_gap8), .rpt_len_err(rpt_len_err8)
    );

    function automatic rpt_t mk(int unsigned f, int unsigned t, int unsigned o,
                                int unsigned g, bit le);
        rpt_t r;
        r.flits = 16'(f); r.toggles = 16'(t); r.ones = 16'(o);
        r.gap = 16'(g); r.len_err = le;
        return r;
    endfunction

    function automatic rpt_t cur_rpt();
        return {rpt_flits, rpt_toggles, rpt_ones, rpt_gap, rpt_len_err};
    endfunction

    task automatic model_clear();
        m_prev = '0; m_flits = 0; m_tog = 0; m_ones = 0;
    endtask

    task automatic model_accept(input logic [DATA_W-1:0] d);
        m_tog   += $countones(d ^ m_prev);
        m_ones  += $countones(d);
        m_flits += 1;
        m_prev   = d;
    endtask

    task automatic close_packet(input int unsigned gap);
        exp_q.push_back(mk(m_flits, m_tog, m_ones, gap, m_flits != PAYLOAD));
        m_flits = 0; m_tog = 0; m_ones = 0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; rpt_ready = 1'b0; in_data = '0;
        model_clear();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic send_flit(input logic [DATA_W-1:0] d, input logic last);
        bit rdy;
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int n = 0; n < 50; n++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (ok) model_accept(d);
        else begin
            checks++; failures++;
            $display("FAIL send_flit_timeout data=%h never accepted", d);
        end
    endtask

    task automatic wait_report(input string name, output rpt_t got, output bit ok);
        ok = 0;
        got = '0;
        for (int n = 0; n < 100; n++) begin
            if (rpt_valid === 1'b1) begin ok = 1; got = cur_rpt(); break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_report_timeout rpt_valid never rose, required 1", name);
        end
    endtask

    task automatic handshake();
        rpt_ready = 1'b1;
        @(posedge clk); #1;
        rpt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rpt_t got, exp;
        bit ok;
        assert_reset();
        checks++;
        if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        checks++;
        if (rpt_valid !== 1'b0) begin failures++;
            $display("FAIL reset_rpt_valid got=%b required=0", rpt_valid); end
        checks++;
        if (cur_rpt() !== '0) begin failures++;
            $display("FAIL reset_rpt_fields got=%p required=all zero", cur_rpt()); end
        release_reset();
        repeat (3) begin @(posedge clk); #1; end
        exp_q.push_back(mk(1, 0, 0, 3, 1'b1));
        send_flit('0, 1'b1);
        m_flits = 0; m_tog = 0; m_ones = 0;
        wait_report("reset", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL reset_single_flit got=%p required=%p", got, exp); end
            handshake();
        end
    endtask

    task automatic test_two_flit();
        rpt_t got, exp;
        bit ok;
        assert_reset();
        release_reset();
        exp_q.push_back(mk(2, 38, 49, 0, 1'b1));
        send_flit(34'h3FFFF8000, 1'b0);
        checks++;
        if (rpt_valid !== 1'b0) begin failures++;
            $display("FAIL two_flit_early_valid got=%b required=0", rpt_valid); end
        send_flit(34'h03FFFFFFF, 1'b1);
        m_flits = 0; m_tog = 0; m_ones = 0;
        checks++;
        if (rpt_valid !== 1'b1) begin failures++;
            $display("FAIL two_flit_latency rpt_valid got=%b required=1", rpt_valid); end
        wait_report("two_flit", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL two_flit_report got=%p required=%p", got, exp); end
            handshake();
        end
    endtask

    task automatic test_full_packet();
        rpt_t got, exp;
        bit ok;
        assert_reset();
        release_reset();
        exp_q.push_back(mk(20, 680, 340, 0, 1'b0));
        for (int i = 0; i < 20; i++) send_flit((i % 2 == 0) ? ALL1 : '0, i == 19);
        m_flits = 0; m_tog = 0; m_ones = 0;
        wait_report("full", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL full_packet_report got=%p required=%p", got, exp); end
            handshake();
        end
        repeat (7) begin @(posedge clk); #1; end
        exp_q.push_back(mk(1, 2, 2, 7, 1'b1));
        send_flit(34'h5, 1'b1);
        m_flits = 0; m_tog = 0; m_ones = 0;
        wait_report("gap7", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL gap_after_handshake got=%p required=%p", got, exp); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        rpt_t got, exp, snap;
        bit ok;
        logic [DATA_W-1:0] b;
        assert_reset();
        release_reset();
        for (int i = 0; i < 3; i++) send_flit({$urandom, $urandom} & ALL1, i == 2);
        close_packet(0);
        wait_report("bp_a", got, ok);
        if (!ok) return;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin failures++;
            $display("FAIL backpressure_first got=%p required=%p", got, exp); end
        snap = got;
        b = {$urandom, $urandom} & ALL1;
        in_valid = 1'b1; in_data = b; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || rpt_valid !== 1'b1 || cur_rpt() !== snap) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d in_ready=%b rpt_valid=%b rpt=%p required in_ready=0 rpt_valid=1 rpt=%p",
                         c, in_ready, rpt_valid, cur_rpt(), snap);
            end
        end
        rpt_ready = 1'b1;
        @(posedge clk); #1;
        rpt_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || rpt_valid !== 1'b0) begin failures++;
            $display("FAIL backpressure_release in_ready=%b rpt_valid=%b required 1/0", in_ready, rpt_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_accept(b);
        close_packet(0);
        checks++;
        if (rpt_valid !== 1'b1) begin failures++;
            $display("FAIL backpressure_pending_accept rpt_valid=%b required=1", rpt_valid); end
        wait_report("bp_b", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL backpressure_second got=%p required=%p", got, exp); end
            handshake();
        end
    endtask

    task automatic test_saturation();
        rpt_t got, exp;
        bit ok;
        logic [32:0] got8;
        assert_reset();
        release_reset();
        exp_q.push_back(mk(20, 680, 340, 0, 1'b0));
        for (int i = 0; i < 20; i++) send_flit((i % 2 == 0) ? ALL1 : '0, i == 19);
        m_flits = 0; m_tog = 0; m_ones = 0;
        wait_report("sat", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL sat_wide_report got=%p required=%p", got, exp); end
            got8 = {rpt_flits8, rpt_toggles8, rpt_ones8, rpt_gap8, rpt_len_err8};
            checks++;
            if (got8 !== {8'd20, 8'd255, 8'd255, 8'd0, 1'b0} || rpt_valid8 !== 1'b1) begin
                failures++;
                $display("FAIL sat_cnt8 flits=%0d toggles=%0d ones=%0d gap=%0d len_err=%b valid=%b required 20/255/255/0/0/1",
                         rpt_flits8, rpt_toggles8, rpt_ones8, rpt_gap8, rpt_len_err8, rpt_valid8);
            end
            handshake();
        end
    endtask

    task automatic test_reset_mid_packet();
        rpt_t got, exp;
        bit ok;
        assert_reset();
        release_reset();
        for (int i = 0; i < 5; i++) send_flit({$urandom, $urandom} & ALL1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || rpt_valid !== 1'b0 || cur_rpt() !== '0) begin failures++;
            $display("FAIL async_reset in_ready=%b rpt_valid=%b rpt=%p required 1/0/zero",
                     in_ready, rpt_valid, cur_rpt()); end
        @(posedge clk); #1;
        release_reset();
        exp_q.push_back(mk(1, 1, 1, 0, 1'b1));
        send_flit(34'h1, 1'b1);
        m_flits = 0; m_tog = 0; m_ones = 0;
        wait_report("mid_reset", got, ok);
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL reset_mid_packet got=%p required=%p", got, exp); end
            handshake();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_two_flit();
        test_full_packet();
        test_backpressure();
        test_saturation();
        test_reset_mid_packet();
        checks++;
        if (exp_q.size() != 0) begin failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
